// File: rtl/sa_tile_ctrl.sv
// sa_tile_ctrl: sequencer for one output-stationary ROWS x COLS tile of INT8 PEs.
// Each accepted command walks the tile through CLEAR, FEED, FLUSH and DRAIN and
// then returns to IDLE, driving the array-wide pe_en / acc_clr strobes.
//
// Ports
//   clk, rstn           clock (posedge) and asynchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_k = reduction depth K, latched on accept
//   abort               synchronous abort of the current tile (ignored in IDLE)
//   feed_valid          skew buffers hold the next a/b vector
//   feed_rd             pop one a/b vector this cycle
//   feed_zero           skew buffers inject zeros while the array flushes
//   pe_en, acc_clr      array-wide PE enable and accumulator clear
//   drain_valid/ready   result row handshake; drain_row = row being drained
//   busy                controller is not IDLE
//   done, err           1-cycle pulses: normal completion / illegal K==0 command
module sa_tile_ctrl #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_BITS = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [K_BITS-1:0]           cmd_k,
  input  logic                        abort,
  input  logic                        feed_valid,
  output logic                        feed_rd,
  output logic                        feed_zero,
  output logic                        pe_en,
  output logic                        acc_clr,
  output logic                        drain_valid,
  input  logic                        drain_ready,
  output logic [($clog2(ROWS)|1)-1:0] drain_row,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int RW   = $clog2(ROWS) | 1;
  localparam int FW   = $clog2(ROWS + COLS);
  // Cycles needed for the last operand to ripple through the skewed array.
  localparam int SKEW = ROWS + COLS - 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ERR   = 3'd1;
  localparam logic [2:0] S_CLEAR = 3'd2;
  localparam logic [2:0] S_FEED  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]        state_q,  state_d;
  logic [K_BITS-1:0] k_last_q, k_last_d;
  logic [K_BITS-1:0] k_cnt_q,  k_cnt_d;
  logic [FW-1:0]     f_cnt_q,  f_cnt_d;
  logic [RW-1:0]     r_cnt_q,  r_cnt_d;

  always_comb begin
    state_d  = state_q;
    k_last_d = k_last_q;
    k_cnt_d  = k_cnt_q;
    f_cnt_d  = f_cnt_q;
    r_cnt_d  = r_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          // Store K-1 so the last-pop compare never needs a K_BITS+1 counter,
          // which keeps K = 2^K_BITS-1 from wrapping early.
          k_last_d = cmd_k - K_BITS'(1);
          state_d  = (cmd_k == '0) ? S_ERR : S_CLEAR;
        end
      end
      S_ERR: state_d = S_IDLE;
      S_CLEAR: begin
        k_cnt_d = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        if (feed_valid) begin
          k_cnt_d = k_cnt_q + K_BITS'(1);
          if (k_cnt_q == k_last_q) begin
            f_cnt_d = '0;
            r_cnt_d = '0;
            if (SKEW == 0) state_d = S_DRAIN;
            else           state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        f_cnt_d = f_cnt_q + FW'(1);
        if (f_cnt_q == FW'(SKEW - 1)) begin
          r_cnt_d = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_ready) begin
          if (r_cnt_q == RW'(ROWS - 1)) state_d = S_DONE;
          else                          r_cnt_d = r_cnt_q + RW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over every other transition, including a drain handshake.
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      k_last_q <= '0;
      k_cnt_q  <= '0;
      f_cnt_q  <= '0;
      r_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_last_q <= k_last_d;
      k_cnt_q  <= k_cnt_d;
      f_cnt_q  <= f_cnt_d;
      r_cnt_q  <= r_cnt_d;
    end
  end

  // Outputs are pure state decode; only feed_rd/pe_en in FEED follow feed_valid.
  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign err         = (state_q == S_ERR);
  assign done        = (state_q == S_DONE);
  assign acc_clr     = (state_q == S_CLEAR);
  assign feed_rd     = (state_q == S_FEED) && feed_valid;
  assign feed_zero   = (state_q == S_FLUSH);
  assign pe_en       = feed_rd || (state_q == S_FLUSH);
  assign drain_valid = (state_q == S_DRAIN);
  assign drain_row   = r_cnt_q;

endmodule

// File: tb/tb_sa_tile_ctrl.sv
module tb_sa_tile_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KB   = 16;
  localparam int SKEW = ROWS + COLS - 2;

  logic clk, rstn;
  logic cmd_valid, cmd_ready, abort, feed_valid, feed_rd, feed_zero, pe_en, acc_clr;
  logic drain_valid, drain_ready, busy, done, err;
  logic [KB-1:0] cmd_k;
  logic [2:0]    drain_row;

  // Second instance: 1x1 tile (no skew) with a narrow K field.
  logic s_cmd_valid, s_cmd_ready, s_abort, s_feed_valid, s_feed_rd, s_feed_zero, s_pe_en;
  logic s_acc_clr, s_drain_valid, s_drain_ready, s_busy, s_done, s_err;
  logic [3:0] s_cmd_k;
  logic [0:0] s_drain_row;

  int checks = 0;
  int errors = 0;
  bit rand_mode = 0;

  sa_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_BITS(KB)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
    .abort(abort), .feed_valid(feed_valid), .feed_rd(feed_rd), .feed_zero(feed_zero),
    .pe_en(pe_en), .acc_clr(acc_clr), .drain_valid(drain_valid), .drain_ready(drain_ready),
    .drain_row(drain_row), .busy(busy), .done(done), .err(err));

  sa_tile_ctrl #(.ROWS(1), .COLS(1), .K_BITS(4)) dut1 (
    .clk(clk), .rstn(rstn), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_k(s_cmd_k),
    .abort(s_abort), .feed_valid(s_feed_valid), .feed_rd(s_feed_rd), .feed_zero(s_feed_zero),
    .pe_en(s_pe_en), .acc_clr(s_acc_clr), .drain_valid(s_drain_valid),
    .drain_ready(s_drain_ready), .drain_row(s_drain_row), .busy(s_busy), .done(s_done),
    .err(s_err));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-tile response, derived from K alone.
  typedef struct {
    bit is_err;
    int pops;
    int flush;
    int clr;
    int pe;
    int rows;
  } exp_t;
  exp_t exp_q[$];

  // Monitor accumulators (written only by the monitor).
  int  m_pops, m_flush, m_clr, m_pe, m_rows;
  bit  m_prev_hold, m_prev_abort;
  int  m_prev_row;

  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      exp_q.delete();
      m_pops = 0; m_flush = 0; m_clr = 0; m_pe = 0; m_rows = 0;
      m_prev_hold = 0; m_prev_abort = 0; m_prev_row = 0;
    end else begin
      if ((int'(acc_clr) + int'(pe_en) + int'(drain_valid)) > 1)
        chk("strobe_exclusive", int'(acc_clr) + int'(pe_en) + int'(drain_valid), 1);
      if (feed_rd) chk("feed_rd_needs_valid", feed_valid, 1);
      if (m_prev_hold && !m_prev_abort) begin
        chk("drain_hold_valid", drain_valid, 1);
        chk("drain_hold_row", drain_row, m_prev_row);
      end
      if (done || err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_end", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_err", err, e.is_err);
          chk("sb_done", done, !e.is_err);
          chk("sb_pops", m_pops, e.pops);
          chk("sb_flush", m_flush, e.flush);
          chk("sb_clr", m_clr, e.clr);
          chk("sb_pe", m_pe, e.pe);
          chk("sb_rows", m_rows, e.rows);
        end
        m_pops = 0; m_flush = 0; m_clr = 0; m_pe = 0; m_rows = 0;
      end else if (abort && busy) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        m_pops = 0; m_flush = 0; m_clr = 0; m_pe = 0; m_rows = 0;
      end else begin
        m_pops  += int'(feed_rd);
        m_flush += int'(feed_zero);
        m_clr   += int'(acc_clr);
        m_pe    += int'(pe_en);
        if (drain_valid && drain_ready) begin
          chk("sb_drain_row", drain_row, m_rows);
          m_rows++;
        end
      end
      m_prev_hold  = drain_valid && !drain_ready;
      m_prev_row   = drain_row;
      m_prev_abort = abort;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      feed_valid  = ($urandom % 4) != 0;
      drain_ready = ($urandom % 3) != 0;
    end
  endtask

  task automatic issue(input int k);
    exp_t e;
    int n = 0;
    while (!cmd_ready && n < 1000) begin tick(); n++; end
    if (!cmd_ready) begin chk("issue_timeout", 0, 1); return; end
    e.is_err = (k == 0);
    e.pops   = k;
    e.flush  = (k == 0) ? 0 : SKEW;
    e.clr    = (k == 0) ? 0 : 1;
    e.pe     = (k == 0) ? 0 : k + SKEW;
    e.rows   = (k == 0) ? 0 : ROWS;
    exp_q.push_back(e);
    cmd_k     = KB'(k);
    cmd_valid = 1;
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    if (busy) chk(name, 1, 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!drain_valid && n < 200) begin tick(); n++; end
    if (!drain_valid) chk("wait_drain_timeout", 0, 1);
  endtask

  task automatic chk_rst_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_strobes"}, {feed_rd, feed_zero, pe_en, acc_clr, drain_valid, done, err}, 0);
    chk({tag, "_drain_row"}, drain_row, 0);
    chk({tag, "_s_cmd_ready"}, s_cmd_ready, 1);
    chk({tag, "_s_strobes"}, {s_busy, s_feed_rd, s_feed_zero, s_pe_en, s_acc_clr,
                              s_drain_valid, s_done, s_err}, 0);
  endtask

  initial begin
    int pops;
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    rstn = 0; cmd_valid = 0; cmd_k = '0; abort = 0; feed_valid = 0; drain_ready = 0;
    s_cmd_valid = 0; s_cmd_k = '0; s_abort = 0; s_feed_valid = 0; s_drain_ready = 0;
    #12;
    chk_rst_outputs("reset");
    #10 rstn = 1;
    tick();

    // Ideal 4x4 run, K=8: cycle-exact timeline.
    feed_valid = 1; drain_ready = 1;
    issue(8);
    chk("t1_acc_clr", acc_clr, 1);
    chk("t1_pe_en_clear", pe_en, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t1_feed_rd", feed_rd, 1);
      chk("t1_feed_pe_en", pe_en, 1);
    end
    for (int i = 0; i < SKEW; i++) begin
      tick();
      chk("t1_feed_zero", feed_zero, 1);
      chk("t1_flush_no_rd", feed_rd, 0);
    end
    for (int r = 0; r < ROWS; r++) begin
      tick();
      chk("t1_drain_valid", drain_valid, 1);
      chk("t1_drain_row", drain_row, r);
      chk("t1_drain_pe_en", pe_en, 0);
    end
    tick();
    chk("t1_done", done, 1);
    chk("t1_ready_at_done", cmd_ready, 0);
    tick();
    chk("t1_ready_after", cmd_ready, 1);
    chk("t1_done_pulse", done, 0);

    // K=0 command.
    issue(0);
    chk("t2_err", err, 1);
    chk("t2_quiet", {acc_clr, pe_en, feed_rd}, 0);
    tick();
    chk("t2_ready", cmd_ready, 1);
    chk("t2_err_pulse", err, 0);

    // Stalling feed.
    issue(4);
    for (int i = 0; i < 7; i++) begin
      tick();
      feed_valid = pat[i][0];
      #1;
      chk("t3_feed_rd", feed_rd, pat[i]);
      chk("t3_pe_en", pe_en, pat[i]);
      chk("t3_no_zero", feed_zero, 0);
    end
    tick();
    chk("t3_flush_start", feed_zero, 1);
    feed_valid = 1;
    wait_idle("t3_timeout");

    // Drain back-pressure on row 1.
    issue(2);
    wait_drain();
    chk("t4_row0", drain_row, 0);
    tick();
    drain_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_valid", drain_valid, 1);
      chk("t4_hold_row", drain_row, 1);
      tick();
    end
    drain_ready = 1;
    chk("t4_row1_again", drain_row, 1);
    tick();
    chk("t4_row2", drain_row, 2);
    tick();
    chk("t4_row3", drain_row, 3);
    chk("t4_no_early_done", done, 0);
    tick();
    chk("t4_done", done, 1);
    tick();

    // Abort in FEED with k_cnt=3, then abort in DRAIN during a handshake.
    issue(8);
    for (int i = 0; i < 4; i++) tick();
    abort = 1;
    tick();
    abort = 0;
    chk("t5a_idle", cmd_ready, 1);
    chk("t5a_done", done, 0);
    issue(3);
    wait_drain();
    tick();
    chk("t5b_row1", drain_row, 1);
    abort = 1; drain_ready = 1;
    tick();
    abort = 0;
    chk("t5b_idle", cmd_ready, 1);
    chk("t5b_quiet", {done, err, drain_valid}, 0);
    tick();
    chk("t5b_no_done", done, 0);
    issue(2);
    wait_idle("t5c_timeout");

    // Asynchronous reset mid-FLUSH.
    issue(8);
    for (int i = 0; i < 11; i++) tick();
    chk("t6_in_flush", feed_zero, 1);
    #2 rstn = 0;
    #1;
    chk_rst_outputs("t6_async");
    @(posedge clk);
    #3 rstn = 1;
    tick();

    // 1x1 tile: CLEAR -> FEED -> DRAIN -> DONE.
    s_feed_valid = 1; s_drain_ready = 1; s_cmd_k = 4'd1; s_cmd_valid = 1;
    tick();
    s_cmd_valid = 0;
    chk("t6s_clear", s_acc_clr, 1);
    tick();
    chk("t6s_feed", {s_feed_rd, s_pe_en}, 3);
    tick();
    chk("t6s_drain", {s_drain_valid, s_feed_zero, s_pe_en}, 4);
    chk("t6s_row", s_drain_row, 0);
    tick();
    chk("t6s_done", s_done, 1);
    tick();
    chk("t6s_ready", s_cmd_ready, 1);

    // Widest K on the narrow instance must not wrap early.
    s_cmd_k = 4'd15; s_cmd_valid = 1;
    tick();
    s_cmd_valid = 0;
    pops = 0;
    for (int i = 0; i < 40 && !s_drain_valid; i++) begin
      tick();
      pops += int'(s_feed_rd);
    end
    chk("kmax_pops", pops, 15);
    chk("kmax_drain", s_drain_valid, 1);
    tick();
    chk("kmax_done", s_done, 1);

    // Randomized traffic against the scoreboard.
    rand_mode = 1;
    for (int n = 0; n < 30; n++) begin
      int k = $urandom_range(0, 12);
      issue(k);
      if (($urandom % 5) == 0) begin
        int w = $urandom_range(0, 10);
        for (int i = 0; i < w; i++) tick();
        if (busy && !done && !err) begin
          abort = 1;
          tick();
          abort = 0;
        end
      end
      wait_idle("rand_timeout");
    end
    rand_mode = 0;
    tick();
    tick();
    chk("sb_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
